fetch_controller: RTL and testbench

Sequences the instruction-fetch bus: it issues PC-ordered read addresses on the i_raddr channel and keeps up to max_outstanding reads in flight. Returned instructions are buffered with their PC and presented to decode through a valid/ready interface. A branch or jump redirect flushes the buffer, discards stale in-flight responses and restarts fetch at the new PC. Sits between the core's i-bus ports and the instruction decoder, replacing the free-running pc/inst registers.

---
 rtl/fetch_controller.sv | 149 ++++++++++++++
 tb/tb_fetch_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// fetch_controller: PC-ordered i-bus read sequencer with credit-limited
// outstanding reads and an instruction buffer. Redirects flush stale data.
// Revision: 1.0
// ============================================================================
module fetch_controller #(
    parameter int                  BUS_WIDTH       = 32,
    parameter int                  PC_WIDTH        = 32,
    parameter logic [PC_WIDTH-1:0] PC_INIT         = '0,
    parameter int                  INST_WIDTH      = 32,
    parameter int                  MAX_OUTSTANDING = 2,
    parameter int                  BUF_DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  i_raddr_valid,
    input  logic                  i_raddr_ready,
    output logic [BUS_WIDTH-1:0]  i_raddr,
    input  logic                  i_rdata_valid,
    output logic                  i_rdata_ready,
    input  logic [BUS_WIDTH-1:0]  i_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int SW = ((OW > AW + 1) ? OW : AW + 1) + 1;
    localparam logic [SW-1:0] MAX_OUT = SW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] DEPTH   = SW'(BUF_DEPTH);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REQ       = 2'd1;
    localparam logic [1:0] REQ_STALE = 2'd2;

    logic [1:0]            state, state_nxt;
    logic [PC_WIDTH-1:0]   fetch_pc, fetch_nxt, resp_pc, target_pc;
    logic [BUS_WIDTH-1:0]  raddr;
    logic [OW-1:0]         outstanding, out_nxt, drop_cnt, drop_nxt;
    logic                  rdata_ready;
    logic [AW:0]           wr_ptr, rd_ptr, buf_count, count_nxt;
    logic [INST_WIDTH-1:0] buf_inst [BUF_DEPTH];
    logic [PC_WIDTH-1:0]   buf_pc   [BUF_DEPTH];

    logic accept, beat, discard, push, pop, credit;
    logic [SW-1:0] out_ext, count_ext;

    assign accept    = (state != IDLE) && i_raddr_ready;
    assign beat      = i_rdata_valid && rdata_ready;
    assign discard   = beat && (drop_cnt != '0);
    assign push      = beat && !discard && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;
    assign target_pc = redirect_pc & ~PC_WIDTH'(3);
    assign buf_count = wr_ptr - rd_ptr;

    assign out_nxt   = outstanding + OW'(accept) - OW'(beat);
    assign count_nxt = redirect_valid ? '0 : buf_count + (AW+1)'(push) - (AW+1)'(pop);
    assign out_ext   = {{(SW-OW){1'b0}}, out_nxt};
    assign count_ext = {{(SW-AW-1){1'b0}}, count_nxt};

    // Credit is judged on post-edge counts so a newly committed address always has buffer room.
    assign credit = (out_ext < MAX_OUT) && ((out_ext + count_ext) < DEPTH);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!redirect_valid && credit) state_nxt = REQ;
            end
            REQ: begin
                if (redirect_valid)  state_nxt = accept ? IDLE : REQ_STALE;
                else if (accept)     state_nxt = credit ? REQ : IDLE;
            end
            REQ_STALE: begin
                if (accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fetch_nxt = fetch_pc;
        if (redirect_valid)              fetch_nxt = target_pc;
        else if (state == REQ && accept) fetch_nxt = fetch_pc + PC_WIDTH'(4);
    end

    // On redirect everything still in flight (including a same-edge accept) is stale.
    always_comb begin
        if (redirect_valid) drop_nxt = out_nxt;
        else                drop_nxt = drop_cnt - OW'(discard) + OW'((state == REQ_STALE) && accept);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            fetch_pc    <= PC_INIT;
            resp_pc     <= PC_INIT;
            raddr       <= BUS_WIDTH'(PC_INIT);
            outstanding <= '0;
            drop_cnt    <= '0;
            rdata_ready <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_nxt;
            outstanding <= out_nxt;
            drop_cnt    <= drop_nxt;
            rdata_ready <= 1'b1;
            if (!((state != IDLE) && !accept)) raddr <= BUS_WIDTH'(fetch_nxt);
            if (redirect_valid) begin
                resp_pc <= target_pc;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                if (push) resp_pc <= resp_pc + PC_WIDTH'(4);
                wr_ptr <= wr_ptr + (AW+1)'(push);
                rd_ptr <= rd_ptr + (AW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr[AW-1:0]] <= i_rdata[INST_WIDTH-1:0];
            buf_pc[wr_ptr[AW-1:0]]   <= resp_pc;
        end
    end

    assign i_raddr_valid = (state != IDLE);
    assign i_raddr       = raddr;
    assign i_rdata_ready = rdata_ready;
    assign inst_valid    = (buf_count != '0);
    assign inst          = buf_inst[rd_ptr[AW-1:0]];
    assign inst_pc       = buf_pc[rd_ptr[AW-1:0]];

`ifndef SYNTHESIS
    a_no_orphan_beat: assert property (@(posedge clk) disable iff (!rst) beat |-> (outstanding != '0));
    a_out_bound:      assert property (@(posedge clk) disable iff (!rst) ({{(SW-OW){1'b0}}, outstanding} <= MAX_OUT));
    a_buf_bound:      assert property (@(posedge clk) disable iff (!rst) ({{(SW-AW-1){1'b0}}, buf_count} <= DEPTH));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// tb_fetch_controller: directed bench with a transaction-level fetch model.
// Revision: 1.0
// ============================================================================
module tb_fetch_controller;

    localparam logic [31:0] PAT = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_raddr_ready, rdata_valid, inst_ready, redirect_valid;
    logic [31:0] rdata, redirect_pc;
    logic        raddr_valid, rdata_ready, inst_valid;
    logic [31:0] raddr, inst, inst_pc;
    logic        w_raddr_valid, w_rdata_ready, w_rdata_valid, w_inst_valid;
    logic [31:0] w_raddr, w_rdata, w_inst, w_inst_pc;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk(clk), .rst(rst),
        .i_raddr_valid(raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(raddr),
        .i_rdata_valid(rdata_valid), .i_rdata_ready(rdata_ready), .i_rdata(rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    fetch_controller #(.PC_INIT(32'hFFFFFFF8)) dut_w (
        .clk(clk), .rst(rst),
        .i_raddr_valid(w_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(w_raddr),
        .i_rdata_valid(w_rdata_valid), .i_rdata_ready(w_rdata_ready), .i_rdata(w_rdata),
        .inst_valid(w_inst_valid), .inst_ready(inst_ready), .inst(w_inst), .inst_pc(w_inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct { logic stale; logic [31:0] pc; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mr_t;

    fl_t         infl[$];
    ent_t        mbuf[$];
    mr_t         memq[$];
    logic [31:0] pops_pc[$], pops_d[$], accs[$], wpops[$];
    logic [31:0] m_fetch, prev_addr, w_paddr;
    bit          held_stale, prev_hold, w_pend, hold;
    int          lat, ecnt, last_due;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxxxxxx;
    endfunction

    // One clock: fold this edge's bus events into the model, then compare after the edge.
    task automatic tick();
        bit acc, beat, mpop, rst_edge;
        fl_t e;
        rst_edge = rst;
        acc  = raddr_valid && i_raddr_ready;
        beat = rdata_valid && rdata_ready;
        if (!rst) begin
            infl.delete(); mbuf.delete(); memq.delete();
            m_fetch = 32'h0; held_stale = 0; prev_hold = 0; w_pend = 0;
        end else begin
            if (prev_hold) begin
                chk("addr_hold_valid", raddr_valid, 1);
                chk("addr_hold_value", raddr, prev_addr);
            end
            prev_hold = raddr_valid && !i_raddr_ready;
            prev_addr = raddr;
            mpop = (mbuf.size() != 0) && inst_ready && !redirect_valid;
            if (inst_valid && inst_ready && !redirect_valid) begin
                pops_pc.push_back(inst_pc);
                pops_d.push_back(inst);
            end
            if (w_inst_valid && inst_ready && !redirect_valid) wpops.push_back(w_inst_pc);
            if (beat) begin
                void'(memq.pop_front());
                if (infl.size() == 0) chk("orphan_beat", 1, 0);
                else begin
                    e = infl.pop_front();
                    if (!e.stale && !redirect_valid) mbuf.push_back('{e.pc, e.pc ^ PAT});
                end
            end
            if (mpop) void'(mbuf.pop_front());
            if (acc) begin
                if (held_stale || redirect_valid) infl.push_back('{1'b1, raddr});
                else begin
                    chk("fetch_addr", raddr, m_fetch);
                    infl.push_back('{1'b0, m_fetch});
                    m_fetch = m_fetch + 32'd4;
                end
                held_stale = 0;
                accs.push_back(raddr);
                last_due = (ecnt + 1 + lat > last_due) ? ecnt + 1 + lat : last_due + 1;
                memq.push_back('{raddr, last_due});
            end
            if (redirect_valid) begin
                foreach (infl[i]) infl[i].stale = 1'b1;
                mbuf.delete();
                m_fetch = redirect_pc & ~32'd3;
                held_stale = raddr_valid && !acc;
            end
            w_pend  = w_raddr_valid && i_raddr_ready;
            w_paddr = w_raddr;
        end
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        if (!rst_edge) begin
            chk("reset_raddr_valid", raddr_valid, 0);
            chk("reset_inst_valid", inst_valid, 0);
            chk("reset_raddr", raddr, 32'h0);
            chk("reset_rdata_ready", rdata_ready, 0);
        end else begin
            chk("rdata_ready", rdata_ready, 1);
            chk("inst_valid", inst_valid, (mbuf.size() != 0));
            if (mbuf.size() != 0 && inst_valid) begin
                chk("inst_pc", inst_pc, mbuf[0].pc);
                chk("inst", inst, mbuf[0].data);
            end
            chk("outstanding_bound", (infl.size() <= 2), 1);
            chk("credit_bound", (infl.size() + mbuf.size() <= 4), 1);
        end
        rdata_valid   = (memq.size() != 0) && (memq[0].due <= ecnt + 1);
        rdata         = (memq.size() != 0) ? (memq[0].addr ^ PAT) : 32'h0;
        w_rdata_valid = rst_edge && w_pend;
        w_rdata       = w_paddr ^ PAT;
    endtask

    task automatic htick();
        if (hold) i_raddr_ready = !(raddr_valid && raddr == 32'h20);
        tick();
    endtask

    initial begin
        rst = 1'b0; i_raddr_ready = 1'b1; rdata_valid = 1'b0; rdata = 32'h0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        w_rdata_valid = 1'b0; w_rdata = 32'h0; hold = 0;
        lat = 1; ecnt = 0; last_due = 0;
        @(negedge clk);
        repeat (3) tick();

        // Stall decode from the start: the buffer fills to the credit limit.
        rst = 1'b1;
        repeat (20) tick();
        chk("stall_inst_valid", inst_valid, 1);
        chk("stall_raddr_valid", raddr_valid, 0);
        chk("stall_head_pc", inst_pc, 32'h0);
        chk("stall_fill", mbuf.size(), 4);
        chk("stall_inflight", infl.size(), 0);
        pops_pc.delete(); accs.delete();
        inst_ready = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 4; i++) chk($sformatf("resume_pc%0d", i), qat(pops_pc, i), 32'(4 * i));
        chk("resume_fetch", qat(accs, 0), 32'h10);
        chk("wrap_pc0", qat(wpops, 0), 32'hFFFFFFF8);
        chk("wrap_pc1", qat(wpops, 1), 32'hFFFFFFFC);
        chk("wrap_pc2", qat(wpops, 2), 32'h00000000);

        // Steady streaming: one instruction per cycle.
        repeat (10) tick();
        pops_pc.delete();
        repeat (16) tick();
        chk("stream_rate", pops_pc.size(), 16);

        // Redirect with two reads in flight and data buffered.
        i_raddr_ready = 1'b0;
        repeat (8) tick();
        lat = 2; i_raddr_ready = 1'b1; inst_ready = 1'b0;
        for (int i = 0; i < 20 && !(infl.size() == 2 && mbuf.size() >= 1); i++) tick();
        chk("redir_setup", (infl.size() == 2 && mbuf.size() >= 1), 1);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        chk("redir_flush", inst_valid, 0);
        pops_pc.delete(); pops_d.delete();
        inst_ready = 1'b1;
        for (int i = 0; i < 30 && pops_pc.size() == 0; i++) tick();
        chk("redir_first_pc", qat(pops_pc, 0), 32'h100);
        chk("redir_first_inst", qat(pops_d, 0), 32'h100 ^ PAT);

        // Redirect while an unaccepted address is held on the bus.
        lat = 1; hold = 1;
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        htick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !(raddr_valid && raddr == 32'h20); i++) htick();
        chk("hold_reached", raddr, 32'h20);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        htick();
        redirect_valid = 1'b0;
        htick();
        chk("hold_addr", raddr, 32'h20);
        chk("hold_valid", raddr_valid, 1);
        accs.delete(); pops_pc.delete();
        hold = 0; i_raddr_ready = 1'b1;
        for (int i = 0; i < 20 && (accs.size() < 2 || pops_pc.size() == 0); i++) tick();
        chk("hold_acc0", qat(accs, 0), 32'h20);
        chk("hold_acc1", qat(accs, 1), 32'h80);
        chk("hold_first_pc", qat(pops_pc, 0), 32'h80);

        // Reset mid-stream with two reads outstanding.
        lat = 2;
        for (int i = 0; i < 20 && infl.size() != 2; i++) tick();
        chk("midrst_setup", infl.size(), 2);
        rst = 1'b0;
        tick();
        chk("midrst_raddr_valid", raddr_valid, 0);
        chk("midrst_inst_valid", inst_valid, 0);
        chk("midrst_raddr", raddr, 32'h0);
        rst = 1'b1;
        accs.delete(); pops_pc.delete();
        for (int i = 0; i < 20 && pops_pc.size() == 0; i++) tick();
        chk("midrst_acc0", qat(accs, 0), 32'h0);
        chk("midrst_first_pc", qat(pops_pc, 0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
